irq_ctrl: RTL and testbench



---
 rtl/irq_ctrl_pkg.sv | 18 +
 rtl/irq_prio_enc.sv | 22 ++
 rtl/irq_ctrl.sv | 134 +++++++++++++
 tb/tb_irq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants and FSM encoding for irq_ctrl
//   Register word indices within the 0x7f20 window, base address, state enum.
package irq_ctrl_pkg;

  localparam logic [31:0] BASE_ADDR = 32'h00007f20;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_MODE = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BUSY  = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder
//   req   in  N_IRQ  request vector, bit 0 highest priority
//   valid out 1      any request set
//   idx   out 3      index of the lowest set bit (0 when none)
module irq_prio_enc #(
  parameter int N_IRQ = 3
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [2:0]       idx
);

  always_comb begin
    valid = |req;
    idx   = 3'd0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - memory-mapped interrupt controller for the device bus
//   clk     in  1      system clock
//   reset   in  1      synchronous, active-low
//   Addr    in  30     word address, [3:2] selects PEND/MASK/MODE/STATUS
//   WD      in  32     write data
//   WE      in  1      write enable (already decoded for this window)
//   RD      out 32     read data, combinational from Addr[3:2]
//   irq_in  in  N_IRQ  raw lines: [0] DEV0, [1] DEV1, [2] external
//   int_ack in  1      CP0 exception-entry pulse
//   HWInt   out [7:2]  one-hot line of the armed source, else 0
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic [31:0]      WD,
  input  logic             WE,
  output logic [31:0]      RD,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             int_ack,
  output logic [7:2]       HWInt
);

  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] mode;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] pend_next;
  logic [2:0]       id;
  logic [2:0]       sel;
  logic             sel_valid;
  state_t           state;
  state_t           state_next;

  logic wr_pend;
  logic wr_mask;
  logic wr_mode;
  logic wr_eoi;
  logic take_ack;

  // Upper address bits and unused write-data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{Addr[31:4], WD[31:N_IRQ]};

  assign wr_pend = WE && (Addr[3:2] == REG_PEND);
  assign wr_mask = WE && (Addr[3:2] == REG_MASK);
  assign wr_mode = WE && (Addr[3:2] == REG_MODE);
  assign wr_eoi  = WE && (Addr[3:2] == REG_STAT);

  assign elig = pending & mask;

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
    .req   (elig),
    .valid (sel_valid),
    .idx   (sel)
  );

  assign take_ack = (state == ARMED) && int_ack && sel_valid;

  // Edge lines: a fresh rising edge wins over any clear in the same cycle;
  // clears come from W1C or from acknowledging the selected line.
  // Level lines simply mirror the input, so clears cannot stick.
  always_comb begin
    pend_next = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (mode[i]) begin
        pend_next[i] = (irq_in[i] & ~irq_q[i])
                     | (pending[i] & ~((wr_pend & WD[i]) | (take_ack & (sel == 3'(i)))));
      end else begin
        pend_next[i] = irq_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
      irq_q   <= '0;
      id      <= 3'd0;
    end else begin
      pending <= pend_next;
      irq_q   <= irq_in;
      if (wr_mask) mask <= WD[N_IRQ-1:0];
      if (wr_mode) mode <= WD[N_IRQ-1:0];
      if (take_ack) id <= sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (sel_valid) state_next = ARMED;
      end
      ARMED: begin
        if (!sel_valid)   state_next = IDLE;
        else if (int_ack) state_next = BUSY;
      end
      BUSY: begin
        if (wr_eoi) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // HWInt follows sel while armed so a higher-priority arrival takes over.
  always_comb begin
    HWInt = 6'b000000;
    if ((state == ARMED) && sel_valid) HWInt = 6'b000001 << sel;
  end

  always_comb begin
    RD = 32'd0;
    case (Addr[3:2])
      REG_PEND: RD = {{(32-N_IRQ){1'b0}}, pending};
      REG_MASK: RD = {{(32-N_IRQ){1'b0}}, mask};
      REG_MODE: RD = {{(32-N_IRQ){1'b0}}, mode};
      REG_STAT: RD = {(state == BUSY), 28'd0, id};
      default:  RD = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam logic [29:0] A0 = 30'(BASE_ADDR >> 2);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] Addr;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic [2:0]  irq_in;
  logic        int_ack;
  logic [7:2]  HWInt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the controller should hold after each edge.
  bit [2:0] m_pend, m_mask, m_mode, m_prev;
  bit       m_armed, m_busy;
  int       m_id;

  irq_ctrl #(.N_IRQ(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WD      (WD),
    .WE      (WE),
    .RD      (RD),
    .irq_in  (irq_in),
    .int_ack (int_ack),
    .HWInt   (HWInt)
  );

  always #5 clk = ~clk;

  function automatic int low_idx(bit [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(bit rst_n, bit we, bit [1:0] widx, bit [31:0] wd,
                            bit [2:0] irq, bit ack);
    bit [2:0] np;
    int top;
    if (!rst_n) begin
      m_pend = 0; m_mask = 0; m_mode = 0; m_prev = 0;
      m_armed = 0; m_busy = 0; m_id = 0;
      return;
    end
    top = low_idx(m_pend & m_mask);
    for (int i = 0; i < 3; i++) begin
      if (m_mode[i]) begin
        bit rise, cleared;
        rise    = irq[i] && !m_prev[i];
        cleared = (we && widx == 2'd0 && wd[i]) || (m_armed && ack && top == i);
        np[i]   = rise || (m_pend[i] && !cleared);
      end else begin
        np[i] = irq[i];
      end
    end
    if (m_busy) begin
      if (we && widx == 2'd3) m_busy = 0;
    end else if (m_armed) begin
      if (top < 0) m_armed = 0;
      else if (ack) begin m_armed = 0; m_busy = 1; m_id = top; end
    end else if (top >= 0) begin
      m_armed = 1;
    end
    if (we && widx == 2'd1) m_mask = wd[2:0];
    if (we && widx == 2'd2) m_mode = wd[2:0];
    m_pend = np;
    m_prev = irq;
  endtask

  function automatic logic [5:0] exp_hw();
    int top;
    top = low_idx(m_pend & m_mask);
    if (m_armed && top >= 0) return 6'(1 << top);
    return 6'd0;
  endfunction

  function automatic logic [31:0] exp_rd(int r);
    case (r)
      0: return {29'd0, m_pend};
      1: return {29'd0, m_mask};
      2: return {29'd0, m_mode};
      default: return {m_busy, 28'd0, 3'(m_id)};
    endcase
  endfunction

  task automatic tick(bit we, bit [1:0] widx, bit [31:0] wd, bit [2:0] irq, bit ack);
    WE = we;
    if (we) Addr = A0 + 30'(widx);
    WD = wd;
    irq_in = irq;
    int_ack = ack;
    model_step(1'b1, we, widx, wd, irq, ack);
    @(posedge clk);
    #1;
    WE = 1'b0;
    int_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    WE = 1'b0; int_ack = 1'b0; irq_in = 3'd0; WD = 32'd0;
    model_step(1'b0, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    Addr = A0;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      Addr = A0 + 30'(r); #1;
      n_checks++;
      if (RD !== 32'd0) begin
        n_fail++; $display("FAIL reset_rd%0d got %h want %h", r, RD, 32'd0);
      end
    end
    n_checks++;
    if (HWInt !== 6'd0) begin n_fail++; $display("FAIL reset_hwint got %b want 000000", HWInt); end
  endtask

  task automatic test_edge_detect();
    tick(1, 2'd2, 32'd7, 3'b000, 0);
    tick(1, 2'd1, 32'd7, 3'b000, 0);
    tick(0, 2'd0, 0, 3'b010, 0);
    Addr = A0; #1;
    n_checks++;
    if (RD !== 32'h2) begin n_fail++; $display("FAIL edge_pend got %h want %h", RD, 32'h2); end
    n_checks++;
    if (HWInt !== 6'b000000) begin n_fail++; $display("FAIL edge_hw_t1 got %b want 000000", HWInt); end
    tick(0, 2'd0, 0, 3'b000, 0);
    n_checks++;
    if (HWInt !== 6'b000010) begin n_fail++; $display("FAIL edge_hw_t2 got %b want 000010", HWInt); end
    tick(0, 2'd0, 0, 3'b000, 1);
    Addr = A0 + 30'd3; #1;
    n_checks++;
    if (HWInt !== 6'b000000) begin n_fail++; $display("FAIL edge_ack_hw got %b want 000000", HWInt); end
    n_checks++;
    if (RD !== 32'h80000001) begin n_fail++; $display("FAIL edge_status got %h want 80000001", RD); end
    tick(1, 2'd3, 0, 3'b000, 0);
  endtask

  task automatic test_priority();
    tick(0, 2'd0, 0, 3'b101, 0);
    tick(0, 2'd0, 0, 3'b000, 0);
    n_checks++;
    if (HWInt !== 6'b000001) begin n_fail++; $display("FAIL prio_first got %b want 000001", HWInt); end
    tick(0, 2'd0, 0, 3'b000, 1);
    tick(1, 2'd3, 0, 3'b000, 0);
    tick(0, 2'd0, 0, 3'b000, 0);
    n_checks++;
    if (HWInt !== 6'b000100) begin n_fail++; $display("FAIL prio_second got %b want 000100", HWInt); end
    tick(0, 2'd0, 0, 3'b000, 1);
    Addr = A0 + 30'd3; #1;
    n_checks++;
    if (RD !== 32'h80000002) begin n_fail++; $display("FAIL prio_status got %h want 80000002", RD); end
    tick(1, 2'd3, 0, 3'b000, 0);
  endtask

  task automatic test_masking();
    tick(1, 2'd1, 32'd0, 3'b000, 0);
    tick(0, 2'd0, 0, 3'b001, 0);
    tick(0, 2'd0, 0, 3'b000, 0);
    Addr = A0 + 30'd3; #1;
    n_checks++;
    if (HWInt !== 6'b000000) begin n_fail++; $display("FAIL mask_off_hw got %b want 000000", HWInt); end
    n_checks++;
    if (RD[31] !== 1'b0) begin n_fail++; $display("FAIL mask_off_busy got %b want 0", RD[31]); end
    tick(1, 2'd1, 32'd1, 3'b000, 0);
    n_checks++;
    if (HWInt !== 6'b000000) begin n_fail++; $display("FAIL mask_on_t1 got %b want 000000", HWInt); end
    tick(0, 2'd0, 0, 3'b000, 0);
    n_checks++;
    if (HWInt !== 6'b000001) begin n_fail++; $display("FAIL mask_on_t2 got %b want 000001", HWInt); end
    tick(1, 2'd1, 32'd0, 3'b000, 0);
    n_checks++;
    if (HWInt !== 6'b000000) begin n_fail++; $display("FAIL mask_drop got %b want 000000", HWInt); end
    tick(1, 2'd0, 32'd7, 3'b000, 0);
  endtask

  task automatic test_level_rearm();
    tick(1, 2'd2, 32'd0, 3'b000, 0);
    tick(1, 2'd1, 32'd1, 3'b001, 0);
    tick(0, 2'd0, 0, 3'b001, 0);
    tick(0, 2'd0, 0, 3'b001, 1);
    tick(1, 2'd3, 0, 3'b001, 0);
    n_checks++;
    if (HWInt !== 6'b000000) begin n_fail++; $display("FAIL level_eoi_t1 got %b want 000000", HWInt); end
    tick(0, 2'd0, 0, 3'b001, 0);
    n_checks++;
    if (HWInt !== 6'b000001) begin n_fail++; $display("FAIL level_rearm got %b want 000001", HWInt); end
    tick(1, 2'd0, 32'd1, 3'b001, 0);
    Addr = A0; #1;
    n_checks++;
    if (RD !== 32'h1) begin n_fail++; $display("FAIL level_w1c got %h want %h", RD, 32'h1); end
    tick(0, 2'd0, 0, 3'b000, 0);
    Addr = A0; #1;
    n_checks++;
    if (RD !== 32'h0) begin n_fail++; $display("FAIL level_drop got %h want %h", RD, 32'h0); end
  endtask

  task automatic test_collision_busy();
    tick(1, 2'd2, 32'd7, 3'b000, 0);
    tick(1, 2'd1, 32'd7, 3'b000, 0);
    tick(0, 2'd0, 0, 3'b010, 0);
    tick(0, 2'd0, 0, 3'b000, 0);
    tick(0, 2'd0, 0, 3'b000, 1);
    tick(0, 2'd0, 0, 3'b010, 0);
    Addr = A0; #1;
    n_checks++;
    if (RD !== 32'h2) begin n_fail++; $display("FAIL busy_latch got %h want %h", RD, 32'h2); end
    tick(0, 2'd0, 0, 3'b000, 0);
    n_checks++;
    if (HWInt !== 6'b000000) begin n_fail++; $display("FAIL busy_hw got %b want 000000", HWInt); end
    tick(0, 2'd0, 0, 3'b000, 1);
    Addr = A0 + 30'd3; #1;
    n_checks++;
    if (RD !== 32'h80000001) begin n_fail++; $display("FAIL busy_ack2 got %h want 80000001", RD); end
    tick(1, 2'd0, 32'd2, 3'b010, 0);
    Addr = A0; #1;
    n_checks++;
    if (RD !== 32'h2) begin n_fail++; $display("FAIL collision got %h want %h", RD, 32'h2); end
    tick(1, 2'd0, 32'd2, 3'b000, 0);
    Addr = A0; #1;
    n_checks++;
    if (RD !== 32'h0) begin n_fail++; $display("FAIL w1c_clear got %h want %h", RD, 32'h0); end
    tick(0, 2'd0, 0, 3'b100, 0);
  endtask

  task automatic test_reset_busy();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      Addr = A0 + 30'(r); #1;
      n_checks++;
      if (RD !== 32'd0) begin
        n_fail++; $display("FAIL rst_busy_rd%0d got %h want %h", r, RD, 32'd0);
      end
    end
    n_checks++;
    if (HWInt !== 6'd0) begin n_fail++; $display("FAIL rst_busy_hw got %b want 000000", HWInt); end
  endtask

  task automatic test_random();
    do_reset();
    tick(1, 2'd2, 32'($urandom_range(0, 7)), 3'b000, 0);
    for (int n = 0; n < 600; n++) begin
      bit        we, ack;
      bit [1:0]  widx;
      bit [31:0] wd;
      int        r;
      we   = ($urandom_range(0, 9) < 3);
      widx = 2'($urandom_range(0, 3));
      wd   = $urandom;
      ack  = ($urandom_range(0, 3) == 0);
      tick(we, widx, wd, 3'($urandom_range(0, 7)), ack);
      n_checks++;
      if (HWInt !== exp_hw()) begin
        n_fail++; $display("FAIL rand_hw[%0d] got %b want %b", n, HWInt, exp_hw());
      end
      r = $urandom_range(0, 3);
      Addr = A0 + 30'(r); #1;
      n_checks++;
      if (RD !== exp_rd(r)) begin
        n_fail++; $display("FAIL rand_rd%0d[%0d] got %h want %h", r, n, RD, exp_rd(r));
      end
    end
  endtask

  initial begin
    reset = 1'b0; Addr = A0; WD = 32'd0; WE = 1'b0; irq_in = 3'd0; int_ack = 1'b0;
    test_reset();
    test_edge_detect();
    test_priority();
    test_masking();
    test_level_rearm();
    test_collision_busy();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
